// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared encodings for the uart command sequencer: FSM states, command opcodes and ack bytes.
// Includes a helper that picks a byte of a 32-bit word, MSB first.
package uart_cmd_ctrl_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ARG, S_RESP, S_READ} pstate_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT} tstate_t;

    localparam logic [7:0] CMD_F   = 8'h46;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_E   = 8'h45;
    localparam logic [7:0] CMD_D   = 8'h44;
    localparam logic [7:0] ACK_K   = 8'h4B;
    localparam logic [7:0] ACK_NAK = 8'h3F;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-level uart link: rx strobes toward the controller, transmit/is_transmitting handshake back.
// master is the command controller side, slave is the uart side.
interface uart_cmd_ctrl_if;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;

    modport master (input  received, rx_byte, recv_error, is_transmitting,
                    output transmit, tx_byte);
    modport slave  (output received, rx_byte, recv_error, is_transmitting,
                    input  transmit, tx_byte);
endinterface

// File: rtl/uart_cmd_ctrl_tx_sched.sv
// Single-byte transmit scheduler: req -> transmit 1 clk later, done after is_transmitting rises then falls.
// A req arriving while the uart is busy is held pending until is_transmitting drops; one byte in flight.
module uart_cmd_ctrl_tx_sched
    import uart_cmd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic [7:0] i_byte,
    input  logic       i_is_transmitting,
    output logic       o_transmit,
    output logic [7:0] o_tx_byte,
    output logic       o_done
);

    tstate_t    r_state;
    logic       r_transmit;
    logic [7:0] r_tx_byte;
    logic       r_done;
    logic       r_pend;
    logic [7:0] r_pend_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= T_IDLE;
            r_transmit  <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_done      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_byte <= 8'h00;
        end else begin
            r_transmit <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                T_IDLE: begin
                    if (i_req || r_pend) begin
                        if (!i_is_transmitting) begin
                            r_transmit <= 1'b1;
                            r_tx_byte  <= i_req ? i_byte : r_pend_byte;
                            r_pend     <= 1'b0;
                            r_state    <= T_START;
                        end else begin
                            r_pend <= 1'b1;
                            if (i_req) r_pend_byte <= i_byte;
                        end
                    end
                end
                T_START: if (i_is_transmitting) r_state <= T_WAIT;
                T_WAIT: begin
                    if (!i_is_transmitting) begin
                        r_done  <= 1'b1;
                        r_state <= T_IDLE;
                    end
                end
                default: r_state <= T_IDLE;
            endcase
        end
    end

    assign o_transmit = r_transmit;
    assign o_tx_byte  = r_tx_byte;
    assign o_done     = r_done;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Uart command parser: 'F'+4 bytes loads freq_word (freq_load 1 clk after last byte, 'K' 2 clk after), 'R' reads back.
// Rx bytes arriving while a response is in progress are dropped and flagged with a 1-cycle overrun.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter logic [31:0] FREQ_RESET   = 32'd0,
    parameter int          TIMEOUT_CLKS = 500000,
    parameter int          TO_W         = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_cmd_ctrl_if.master        uart,
    output logic [31:0]            freq_word,
    output logic                   freq_load,
    output logic                   out_en,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    pstate_t         r_state;
    logic [31:0]     r_shadow;
    logic [31:0]     r_snap;
    logic [31:0]     r_freq_word;
    logic            r_freq_load;
    logic            r_out_en;
    logic            r_overrun;
    logic [1:0]      r_cnt;
    logic [1:0]      r_idx;
    logic [TO_W-1:0] r_timer;
    logic            r_req;
    logic [7:0]      r_req_byte;
    logic            w_done;
    logic [31:0]     w_shift;

    assign w_shift = {r_shadow[23:0], uart.rx_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shadow    <= 32'd0;
            r_snap      <= 32'd0;
            r_freq_word <= FREQ_RESET;
            r_freq_load <= 1'b0;
            r_out_en    <= 1'b0;
            r_overrun   <= 1'b0;
            r_cnt       <= 2'd0;
            r_idx       <= 2'd0;
            r_timer     <= '0;
            r_req       <= 1'b0;
            r_req_byte  <= 8'h00;
        end else begin
            r_freq_load <= 1'b0;
            r_overrun   <= 1'b0;
            r_req       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (uart.received) begin
                        case (uart.rx_byte)
                            CMD_F: begin
                                r_cnt   <= 2'd0;
                                r_timer <= '0;
                                r_state <= S_ARG;
                            end
                            CMD_R: begin
                                r_snap     <= r_freq_word;
                                r_idx      <= 2'd0;
                                r_req      <= 1'b1;
                                r_req_byte <= r_freq_word[31:24];
                                r_state    <= S_READ;
                            end
                            CMD_E, CMD_D: begin
                                r_out_en   <= (uart.rx_byte == CMD_E);
                                r_req      <= 1'b1;
                                r_req_byte <= ACK_K;
                                r_state    <= S_RESP;
                            end
                            default: begin
                                r_req      <= 1'b1;
                                r_req_byte <= ACK_NAK;
                                r_state    <= S_RESP;
                            end
                        endcase
                    end
                end
                S_ARG: begin
                    if (uart.received) begin
                        r_shadow <= w_shift;
                        r_cnt    <= r_cnt + 2'd1;
                        r_timer  <= '0;
                        if (r_cnt == 2'd3) begin
                            r_freq_word <= w_shift;
                            r_freq_load <= 1'b1;
                            r_req       <= 1'b1;
                            r_req_byte  <= ACK_K;
                            r_state     <= S_RESP;
                        end
                    end else if (uart.recv_error || r_timer == TO_LAST) begin
                        // abandon the partial frame; freq_word is left untouched
                        r_shadow   <= 32'd0;
                        r_req      <= 1'b1;
                        r_req_byte <= ACK_NAK;
                        r_state    <= S_RESP;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (uart.received) r_overrun <= 1'b1;
                    if (w_done) r_state <= S_IDLE;
                end
                S_READ: begin
                    if (uart.received) r_overrun <= 1'b1;
                    if (w_done) begin
                        if (r_idx == 2'd3) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx      <= r_idx + 2'd1;
                            r_req      <= 1'b1;
                            r_req_byte <= word_byte(r_snap, r_idx + 2'd1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    uart_cmd_ctrl_tx_sched u_tx (
        .clk               (clk),
        .rst               (rst),
        .i_req             (r_req),
        .i_byte            (r_req_byte),
        .i_is_transmitting (uart.is_transmitting),
        .o_transmit        (uart.transmit),
        .o_tx_byte         (uart.tx_byte),
        .o_done            (w_done)
    );

    assign freq_word = r_freq_word;
    assign freq_load = r_freq_load;
    assign out_en    = r_out_en;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule
